// File: rtl/booth_seq_divider_pkg.sv
// Shared definitions for the sequential signed divider.
package booth_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/booth_seq_divider_restore_step.sv
// One restoring-division step on magnitudes: shift {rem,dq} left, trial-subtract the divisor.
module div_restore_step #(
    parameter int N = 8
) (
    input  logic [N:0]   i_rem,
    input  logic [N-1:0] i_dq,
    input  logic [N:0]   i_dvs,
    output logic [N:0]   o_rem,
    output logic [N-1:0] o_dq
);

    logic [N+1:0] w_sh;
    logic [N+1:0] w_diff;
    logic         w_ge;

    // The borrow out of the widened subtraction is the "trial < 0" test.
    assign w_sh   = {i_rem, i_dq[N-1]};
    assign w_diff = w_sh - {1'b0, i_dvs};
    assign w_ge   = ~w_diff[N+1];

    assign o_rem = w_ge ? w_diff[N:0] : w_sh[N:0];
    assign o_dq  = {i_dq[N-2:0], w_ge};

endmodule

// File: rtl/booth_seq_divider.sv
// Iterative signed divider: one quotient bit per clock, quotient truncated toward zero.
module booth_seq_divider
    import booth_div_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    div_state_t r_state;
    div_state_t w_state_nxt;

    logic [CW-1:0] r_cnt;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_dq;
    logic [N:0]    r_dvs;
    logic          r_sgn_dd;
    logic          r_sgn_dv;
    logic          r_dz;
    logic          r_ovf;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rmd;
    logic          r_dz_o;
    logic          r_ovf_o;

    logic          w_accept;
    logic          w_dz;
    logic          w_ovf;
    logic [N-1:0]  w_min;
    logic [N-1:0]  w_dd_mag;
    logic [N:0]    w_dv_ext;
    logic [N:0]    w_dv_mag;
    logic [N:0]    w_step_rem;
    logic [N-1:0]  w_step_dq;
    logic [N-1:0]  w_dq_neg;
    logic [N-1:0]  w_rem_neg;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_min    = {1'b1, {(N-1){1'b0}}};
    assign w_dz     = (divisor == '0);
    assign w_ovf    = (dividend == w_min) && (divisor == '1);

    // An N-bit unsigned magnitude already holds |-2**(N-1)| exactly.
    assign w_dd_mag = dividend[N-1] ? (~dividend + 1'b1) : dividend;
    assign w_dv_ext = {divisor[N-1], divisor};
    assign w_dv_mag = divisor[N-1] ? (~w_dv_ext + 1'b1) : w_dv_ext;

    assign w_dq_neg  = ~r_dq + 1'b1;
    assign w_rem_neg = ~r_rem[N-1:0] + 1'b1;

    div_restore_step #(
        .N (N)
    ) u_step (
        .i_rem (r_rem),
        .i_dq  (r_dq),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_dq  (w_step_dq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = (w_dz || w_ovf) ? ST_FIX : ST_ITER;
            ST_ITER: if (r_cnt == '0) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dq     <= '0;
            r_dvs    <= '0;
            r_sgn_dd <= 1'b0;
            r_sgn_dv <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_quot   <= '0;
            r_rmd    <= '0;
            r_dz_o   <= 1'b0;
            r_ovf_o  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt    <= CW'(N - 1);
                r_rem    <= '0;
                r_dq     <= w_dd_mag;
                r_dvs    <= w_dv_mag;
                r_sgn_dd <= dividend[N-1];
                r_sgn_dv <= divisor[N-1];
                r_dz     <= w_dz;
                r_ovf    <= w_ovf;
            end else if (r_state == ST_ITER) begin
                r_cnt <= r_cnt - 1'b1;
                r_rem <= w_step_rem;
                r_dq  <= w_step_dq;
            end else if (r_state == ST_FIX) begin
                r_dz_o  <= r_dz;
                r_ovf_o <= r_ovf;
                if (r_dz) begin
                    // No iterations ran, so r_dq still holds |dividend|.
                    r_quot <= '1;
                    r_rmd  <= r_sgn_dd ? w_dq_neg : r_dq;
                end else if (r_ovf) begin
                    r_quot <= w_min;
                    r_rmd  <= '0;
                end else begin
                    r_quot <= (r_sgn_dd ^ r_sgn_dv) ? w_dq_neg : r_dq;
                    r_rmd  <= r_sgn_dd ? w_rem_neg : r_rem[N-1:0];
                end
            end
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign quotient    = r_quot;
    assign remainder   = r_rmd;
    assign div_by_zero = r_dz_o;
    assign overflow    = r_ovf_o;

endmodule
